// File: rtl/eer_rl_pkg.sv
// Shared constants and FSM encoding for the EER-RL routing core neighbour scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eer_rl_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int ADDR_WIDTH = 11;

  localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR  = 11'h274;
  localparam logic [ADDR_WIDTH-1:0] QTABLE_BASE = 11'h132;
  localparam logic [ADDR_WIDTH-1:0] MYBEST_ADDR = 11'h275;

  // Q value marking an unreachable neighbour; such entries never win.
  localparam logic [WORD_WIDTH-1:0] INVALID_Q = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_REQ,
    ST_CNT_WAIT,
    ST_SCAN,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/q_max_cmp.sv
// Decides whether a table entry replaces the running best Q.
// Latency: combinational.
// Backpressure: none.
module q_max_cmp
  import eer_rl_pkg::*;
#(
  parameter bit SIGNED_Q = 1'b0
) (
  input  logic [WORD_WIDTH-1:0] entry,
  input  logic [WORD_WIDTH-1:0] best_q,
  input  logic                  best_valid,
  output logic                  take
);

  logic greater;

  generate
    if (SIGNED_Q) begin : g_signed
      assign greater = $signed(entry) > $signed(best_q);
    end else begin : g_unsigned
      assign greater = entry > best_q;
    end
  endgenerate

  // Strict compare keeps ties on the lowest index; invalid entries never win.
  assign take = (entry != INVALID_Q) && (!best_valid || greater);

endmodule

// File: rtl/find_best_neighbor.sv
// Scans the neighbour Q table in node memory and reports the best entry, optionally writing it back.
// Latency: start to done = 2 cycles (empty table), N+3 (no write-back), N+4 (with write-back).
// Backpressure: none; en low aborts the scan to IDLE on the next edge with no done and no write.
module find_best_neighbor
  import eer_rl_pkg::*;
#(
  parameter int MAX_NBR   = 32,
  parameter bit WRITEBACK = 1'b1,
  parameter bit SIGNED_Q  = 1'b0,
  localparam int IDX_W    = $clog2(MAX_NBR),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic [WORD_WIDTH-1:0] best_q,
  output logic [IDX_W-1:0]      best_idx,
  output logic                  best_valid,
  output logic [CNT_W-1:0]      nbr_count,
  output logic                  clamped,
  output logic                  busy,
  output logic                  done
);

  state_t           state;
  state_t           state_nxt;

  // Two-stage read pipeline: a_* tracks the address on the bus, d_* the word on data_in.
  logic             a_vld;
  logic [CNT_W-1:0] a_idx;
  logic             d_vld;
  logic [CNT_W-1:0] d_idx;
  logic             take;
  logic             last;

  q_max_cmp #(.SIGNED_Q(SIGNED_Q)) u_cmp (
    .entry      (data_in),
    .best_q     (best_q),
    .best_valid (best_valid),
    .take       (take)
  );

  assign last     = d_vld && (d_idx == nbr_count - CNT_W'(1));
  assign busy     = (state != ST_IDLE);
  assign wr_en    = (state == ST_WB) && en;
  assign done     = (state == ST_DONE) && en;
  assign data_out = wr_en ? best_q : '0;

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; en low sends any active state back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_CNT_REQ;
      ST_CNT_REQ:  state_nxt = ST_CNT_WAIT;
      ST_CNT_WAIT: state_nxt = (data_in == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN: begin
        if (last) state_nxt = (WRITEBACK && (best_valid || take)) ? ST_WB : ST_DONE;
      end
      ST_WB:       state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (!en) state_nxt = ST_IDLE;
  end

  // Address generation, count latch, read pipeline and best-entry tracking.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      address    <= COUNT_ADDR;
      best_q     <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
      nbr_count  <= '0;
      clamped    <= 1'b0;
      a_vld      <= 1'b0;
      a_idx      <= '0;
      d_vld      <= 1'b0;
      d_idx      <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            address    <= COUNT_ADDR;
            best_q     <= '0;
            best_idx   <= '0;
            best_valid <= 1'b0;
            clamped    <= 1'b0;
          end
        end
        ST_CNT_WAIT: begin
          if (data_in > WORD_WIDTH'(MAX_NBR)) begin
            nbr_count <= CNT_W'(MAX_NBR);
            clamped   <= 1'b1;
          end else begin
            nbr_count <= data_in[CNT_W-1:0];
          end
          address <= QTABLE_BASE;
          a_vld   <= (data_in != '0);
          a_idx   <= '0;
          d_vld   <= 1'b0;
        end
        ST_SCAN: begin
          d_vld <= a_vld;
          d_idx <= a_idx;
          if (a_vld) begin
            if ((a_idx + CNT_W'(1)) < nbr_count) begin
              address <= address + ADDR_WIDTH'(1);
              a_idx   <= a_idx + CNT_W'(1);
            end else begin
              a_vld <= 1'b0;
            end
          end
          if (d_vld && take) begin
            best_q     <= data_in;
            best_idx   <= d_idx[IDX_W-1:0];
            best_valid <= 1'b1;
          end
          // Address must already point at the write-back slot during WB.
          if (state_nxt == ST_WB) address <= MYBEST_ADDR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_best_neighbor.sv
module tb_find_best_neighbor;
  import eer_rl_pkg::*;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        sel   = 1'b0;
  logic [15:0] mem [0:2047];
  logic [15:0] rd0, rd1;

  logic [10:0] address0, address1;
  logic        wr_en0, wr_en1;
  logic [15:0] data_out0, data_out1;
  logic [15:0] best_q0, best_q1;
  logic [4:0]  best_idx0, best_idx1;
  logic        best_valid0, best_valid1;
  logic [5:0]  nbr_count0, nbr_count1;
  logic        clamped0, clamped1;
  logic        busy0, busy1;
  logic        done0, done1;

  // Unsigned compare with write-back.
  find_best_neighbor #(.MAX_NBR(32), .WRITEBACK(1'b1), .SIGNED_Q(1'b0)) u0 (
    .clock(clock), .rst(rst), .en(en), .start(start0), .data_in(rd0),
    .address(address0), .wr_en(wr_en0), .data_out(data_out0), .best_q(best_q0),
    .best_idx(best_idx0), .best_valid(best_valid0), .nbr_count(nbr_count0),
    .clamped(clamped0), .busy(busy0), .done(done0));

  // Signed compare, no write-back.
  find_best_neighbor #(.MAX_NBR(32), .WRITEBACK(1'b0), .SIGNED_Q(1'b1)) u1 (
    .clock(clock), .rst(rst), .en(en), .start(start1), .data_in(rd1),
    .address(address1), .wr_en(wr_en1), .data_out(data_out1), .best_q(best_q1),
    .best_idx(best_idx1), .best_valid(best_valid1), .nbr_count(nbr_count1),
    .clamped(clamped1), .busy(busy1), .done(done1));

  always #5 clock = ~clock;

  // 1-cycle-latency RAM read ports plus write/done logging.
  int          wr_cnt0 = 0, wr_cnt1 = 0, dn_cnt0 = 0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_dat  = '0;
  always @(posedge clock) begin
    rd0 <= mem[address0];
    rd1 <= mem[address1];
    if (wr_en0) begin
      wr_cnt0 = wr_cnt0 + 1;
      wr_addr = address0;
      wr_dat  = data_out0;
    end
    if (wr_en1) wr_cnt1 = wr_cnt1 + 1;
    if (done0) dn_cnt0 = dn_cnt0 + 1;
  end

  logic        c_done, c_busy, c_valid, c_clamped;
  logic [15:0] c_best_q;
  logic [4:0]  c_best_idx;
  logic [5:0]  c_cnt;
  assign c_done     = sel ? done1       : done0;
  assign c_busy     = sel ? busy1       : busy0;
  assign c_valid    = sel ? best_valid1 : best_valid0;
  assign c_clamped  = sel ? clamped1    : clamped0;
  assign c_best_q   = sel ? best_q1     : best_q0;
  assign c_best_idx = sel ? best_idx1   : best_idx0;
  assign c_cnt      = sel ? nbr_count1  : nbr_count0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit               sel;
    int               count;
    bit               ramp;    // table entry k = 3k+1 instead of q
    logic [7:0][15:0] q;       // q[0] is the rightmost element of the literal
    logic [15:0]      e_q;
    int               e_idx;
    bit               e_vld;
    int               e_cnt;
    bit               e_clamp;
    int               e_lat;   // cycles from accepting edge to done high
    int               e_wr;    // write-back pulses expected
  } vec_t;

  function automatic vec_t mkv(bit s, int cnt, bit rmp, logic [7:0][15:0] q, logic [15:0] eq,
                               int ei, bit ev, int ec, bit ecl, int el, int ew);
    vec_t v;
    v.sel = s; v.count = cnt; v.ramp = rmp; v.q = q; v.e_q = eq; v.e_idx = ei;
    v.e_vld = ev; v.e_cnt = ec; v.e_clamp = ecl; v.e_lat = el; v.e_wr = ew;
    return v;
  endfunction

  task automatic load(input vec_t v);
    mem[COUNT_ADDR] = 16'(v.count);
    for (int k = 0; k < 48; k++) begin
      if (v.ramp)   mem[QTABLE_BASE + 11'(k)] = 16'(3 * k + 1);
      else if (k < 8) mem[QTABLE_BASE + 11'(k)] = v.q[k];
      else          mem[QTABLE_BASE + 11'(k)] = 16'hFFFF;
    end
  endtask

  task automatic kick(input logic s);
    sel = s;
    @(negedge clock);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Runs one scan; poke>0 pulses start0 again while the block is busy.
  task automatic run(input vec_t v, input string tag, input int poke);
    int lat, w0, w1, wr;
    load(v);
    w0 = wr_cnt0;
    w1 = wr_cnt1;
    kick(v.sel);
    chk($sformatf("%s.busy", tag), 32'(c_busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (k == poke) start0 = 1'b1;
      if (k == poke + 1) start0 = 1'b0;
      if (c_done) begin
        lat = k;
        break;
      end
    end
    start0 = 1'b0;
    chk($sformatf("%s.latency", tag), 32'(lat), 32'(v.e_lat));
    chk($sformatf("%s.best_q", tag), 32'(c_best_q), 32'(v.e_q));
    chk($sformatf("%s.best_idx", tag), 32'(c_best_idx), 32'(v.e_idx));
    chk($sformatf("%s.best_valid", tag), 32'(c_valid), 32'(v.e_vld));
    chk($sformatf("%s.nbr_count", tag), 32'(c_cnt), 32'(v.e_cnt));
    chk($sformatf("%s.clamped", tag), 32'(c_clamped), 32'(v.e_clamp));
    wr = v.sel ? (wr_cnt1 - w1) : (wr_cnt0 - w0);
    chk($sformatf("%s.writes", tag), 32'(wr), 32'(v.e_wr));
    if (v.e_wr > 0) begin
      chk($sformatf("%s.wr_addr", tag), 32'(wr_addr), 32'(MYBEST_ADDR));
      chk($sformatf("%s.wr_data", tag), 32'(wr_dat), 32'(v.e_q));
    end
    @(posedge clock);
    #1;
    chk($sformatf("%s.done_pulse", tag), 32'(c_done), 32'd0);
    chk($sformatf("%s.idle", tag), 32'(c_busy), 32'd0);
  endtask

  vec_t vt [9];

  initial begin
    int w0, d0;
    vt[0] = mkv(0, 4,  0, {16'h0, 16'h0, 16'h0, 16'h0, 16'd40, 16'd25, 16'd40, 16'd10},
                16'd40, 1, 1, 4, 0, 8, 1);
    vt[1] = mkv(0, 0,  0, '0, 16'd0, 0, 0, 0, 0, 2, 0);
    vt[2] = mkv(0, 3,  0, {8{16'hFFFF}}, 16'd0, 0, 0, 3, 0, 6, 0);
    vt[3] = mkv(1, 3,  0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0005, 16'hFFF0},
                16'h0005, 1, 1, 3, 0, 6, 0);
    vt[4] = mkv(0, 40, 1, '0, 16'd94, 31, 1, 32, 1, 36, 1);
    vt[5] = mkv(0, 5,  0, {16'h0, 16'h0, 16'h0, 16'd300, 16'hFFFF, 16'd300, 16'd7, 16'hFFFF},
                16'd300, 2, 1, 5, 0, 9, 1);
    vt[6] = mkv(1, 2,  0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h8000},
                16'h8000, 0, 1, 2, 0, 5, 0);
    vt[7] = mkv(0, 1,  0, '0, 16'd0, 0, 1, 1, 0, 5, 1);
    vt[8] = mkv(0, 32, 1, '0, 16'd94, 31, 1, 32, 0, 36, 1);

    for (int i = 0; i < 2048; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.address", 32'(address0), 32'(COUNT_ADDR));
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.done", 32'(done0), 32'd0);
    chk("rst.wr_en", 32'(wr_en0), 32'd0);
    chk("rst.best_q", 32'(best_q0), 32'd0);
    chk("rst.best_valid", 32'(best_valid0), 32'd0);
    chk("rst.nbr_count", 32'(nbr_count0), 32'd0);
    chk("rst.clamped", 32'(clamped0), 32'd0);
    @(negedge clock);
    rst = 1'b0;
    en  = 1'b1;

    for (int i = 0; i < 9; i++) run(vt[i], $sformatf("vec%0d", i), 0);

    // en dropped mid-scan: entries 0 (=5) and 1 (=9) seen, then abort.
    load(mkv(0, 8, 0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd9, 16'd5},
             16'd0, 0, 0, 0, 0, 0, 0));
    w0 = wr_cnt0;
    d0 = dn_cnt0;
    kick(1'b0);
    repeat (5) @(posedge clock);
    #1;
    en = 1'b0;
    @(posedge clock);
    #1;
    chk("en_drop.busy", 32'(busy0), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    en = 1'b1;
    chk("en_drop.best_q", 32'(best_q0), 32'd9);
    chk("en_drop.best_idx", 32'(best_idx0), 32'd1);
    chk("en_drop.best_valid", 32'(best_valid0), 32'd1);
    chk("en_drop.no_done", 32'(dn_cnt0 - d0), 32'd0);
    chk("en_drop.no_write", 32'(wr_cnt0 - w0), 32'd0);
    run(vt[0], "after_en_drop", 0);

    // rst mid-scan
    kick(1'b0);
    repeat (5) @(posedge clock);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_scan.busy", 32'(busy0), 32'd0);
    chk("rst_scan.best_q", 32'(best_q0), 32'd0);
    chk("rst_scan.best_valid", 32'(best_valid0), 32'd0);
    chk("rst_scan.address", 32'(address0), 32'(COUNT_ADDR));
    #1;
    rst = 1'b0;
    run(vt[5], "after_rst_scan", 0);

    // rst during the write-back cycle
    load(vt[0]);
    w0 = wr_cnt0;
    kick(1'b0);
    repeat (7) @(posedge clock);
    #1;
    chk("wb.wr_en", 32'(wr_en0), 32'd1);
    chk("wb.data_out", 32'(data_out0), 32'd40);
    rst = 1'b1;
    #1;
    chk("rst_wb.wr_en", 32'(wr_en0), 32'd0);
    chk("rst_wb.busy", 32'(busy0), 32'd0);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_wb.no_write", 32'(wr_cnt0 - w0), 32'd0);

    // start pulsed while busy must not disturb the scan
    run(vt[0], "start_busy", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
